qpp_ind_gen: RTL and testbench
==============================

Name: qpp_ind_gen

Overview:
- Parametrised successor to the linear turbo-interleaver index counter.
- Emits the linear index i and the LTE QPP interleaved index pi(i) = (f1*i + f2*i^2) mod K for i = 0..K-1, one pair per accepted beat.
- Selectable per block between two sizes, K_A and K_B.
- Sits between the encoder input buffer and the interleaver memory address port.
- Adds a valid/ready handshake, start/done framing and multiplier-free recursive QPP generation.

Parameters:
- IDX_W, 14, width of index outputs; must satisfy 2^IDX_W >= max(K_A, K_B).
- K_A, 1056, block size when k_sel=0.
- F1_A, 17, QPP f1 for K_A.
- F2_A, 66, QPP f2 for K_A.
- K_B, 6144, block size when k_sel=1.
- F1_B, 263, QPP f1 for K_B.
- F2_B, 480, QPP f2 for K_B.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin a block; sampled only in IDLE.
- k_sel  in  1  block-size select; latched on accepted start (0=K_A, 1=K_B).
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  out_idx/out_pi are valid.
- out_idx  out  IDX_W  linear index i.
- out_pi  out  IDX_W  interleaved index pi(i).
- out_last  out  1  high with the beat where i = K-1.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async): state=IDLE; out_valid, out_last, busy, done = 0; out_idx = 0; out_pi = 0; internal g = 0; latched K select = 0.
- IDLE, start=1 at a clock edge:
  - latch k_sel into ksel_r;
  - i = 0, pi = 0, g = (f1+f2) mod K;
  - go to RUN.
- Latency: out_valid rises the cycle after start is sampled.
- RUN: out_valid=1, busy=1. A beat transfers on a clock edge with out_valid & out_ready.
  - On transfer with i < K-1: i += 1; pi = (pi + g) mod K; g = (g + d) mod K, where d = (2*f2) mod K.
  - On transfer with i = K-1: go to IDLE, out_valid=0, done=1 for exactly one cycle.
  - out_ready=0 holds all outputs and internal state stable. Outputs must not change while out_valid & !out_ready.
- Modular add: operands < K, computed at IDX_W+1 bits; subtract K if the sum >= K. No multipliers or dividers.
- out_last = out_valid & (out_idx == K-1).
- start during RUN: ignored, no restart. k_sel changes during RUN: ignored.
- start in the same cycle as the done pulse (already IDLE): accepted normally, giving back-to-back blocks with a one-cycle gap.
- reset mid-block: returns to IDLE immediately. Any partial block is abandoned and done is not pulsed.

Optional Feature:
- Macro QPP_BYPASS_EN.
  - Defined: adds input port bypass (1 bit), latched with k_sel on accepted start. When latched high, out_pi = out_idx (linear order) for the whole block; framing and handshake are unchanged.
  - Undefined: no bypass port; out_pi is always the QPP index.

Decomposition:
- Package qpp_pkg holds:
  - the state enum (IDLE, RUN);
  - the per-size constant set {K, F1, F2, G0 = (F1+F2) mod K, D = (2*F2) mod K};
  - a function selecting the set by ksel.
- One natural sub-module, qpp_mod_add: combinational (a+b) mod K for a,b < K. It is instantiated twice, for the pi update and the g update.

Test Plan:
- Reset, then start with k_sel=0 and out_ready=1 constant -> out_valid the next cycle. Beats (i,pi): (0,0), (1,83), (2,298), (3,645). The last beat (1055,49) has out_last=1; done pulses once in the following cycle; 1056 beats total.
- start with k_sel=1, out_ready=1 -> (0,0), (1,743), (2,2446). The last beat (6143,217) has out_last=1; 6144 beats total; every out_pi is unique (permutation check against a reference model).
- k_sel=0, out_ready toggled pseudo-randomly -> outputs stay stable while stalled; the accepted sequence is identical to the no-stall run.
- Assert start during RUN and flip k_sel mid-block -> the block completes with the original K and no restart occurs.
- Assert reset at beat 500 of a K_B block -> out_valid=0 and busy=0 immediately; no done pulse. A new start with k_sel=0 then produces (0,0), (1,83).
- With QPP_BYPASS_EN defined, start with bypass=1 and k_sel=0 -> out_pi == out_idx for all 1056 beats.

Source files
------------

// File: rtl/qpp_pkg.sv
// Shared types and per-block-size constant sets for the QPP index generator.
// G0 and D seed the multiplier-free recursion pi(i+1) = pi(i) + g(i).
package qpp_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef struct packed {
      int unsigned k;
      int unsigned f1;
      int unsigned f2;
      int unsigned g0;
      int unsigned d;
   } qpp_set_t;

   function automatic qpp_set_t qpp_make(
      input int unsigned k,
      input int unsigned f1,
      input int unsigned f2
   );
      qpp_set_t s;
      s.k  = k;
      s.f1 = f1;
      s.f2 = f2;
      s.g0 = (f1 + f2) % k;
      s.d  = (2 * f2) % k;
      return s;
   endfunction

   function automatic qpp_set_t qpp_sel(
      input logic     ksel,
      input qpp_set_t set_a,
      input qpp_set_t set_b
   );
      return ksel ? set_b : set_a;
   endfunction

endpackage

// File: rtl/qpp_mod_add.sv
// Combinational (a + b) mod k for operands already reduced below k.
// One conditional subtract replaces any divider.
module qpp_mod_add #(
   parameter int W = 14
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] k,
   output logic [W-1:0] y
);

   logic [W:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};
   assign y   = (sum >= {1'b0, k}) ? (sum[W-1:0] - k) : sum[W-1:0];

endmodule

// File: rtl/qpp_ind_gen.sv
// LTE QPP interleaver index generator with valid/ready output and start/done framing.
// Optional QPP_BYPASS_EN adds a bypass input that emits linear order as out_pi.
module qpp_ind_gen #(
   parameter int IDX_W = 14,
   parameter int K_A   = 1056,
   parameter int F1_A  = 17,
   parameter int F2_A  = 66,
   parameter int K_B   = 6144,
   parameter int F1_B  = 263,
   parameter int F2_B  = 480
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             k_sel,
`ifdef QPP_BYPASS_EN
   input  logic             bypass,
`endif
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [IDX_W-1:0] out_pi,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   import qpp_pkg::*;

   localparam qpp_set_t SET_A = qpp_make(K_A, F1_A, F2_A);
   localparam qpp_set_t SET_B = qpp_make(K_B, F1_B, F2_B);

   state_t           state_q, state_d;
   logic             ksel_q, ksel_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] pi_q, pi_d;
   logic [IDX_W-1:0] g_q, g_d;
   logic             done_q, done_d;

   qpp_set_t         set_cur;
   qpp_set_t         set_new;
   logic [IDX_W-1:0] k_cur;
   logic [IDX_W-1:0] d_cur;
   logic [IDX_W-1:0] g0_new;
   logic [IDX_W-1:0] pi_nxt;
   logic [IDX_W-1:0] g_nxt;
   logic             at_last;
   logic             unused_bits;

   assign set_cur = qpp_sel(ksel_q, SET_A, SET_B);
   assign set_new = qpp_sel(k_sel, SET_A, SET_B);
   assign k_cur   = set_cur.k[IDX_W-1:0];
   assign d_cur   = set_cur.d[IDX_W-1:0];
   assign g0_new  = set_new.g0[IDX_W-1:0];
   assign at_last = (idx_q == k_cur - IDX_W'(1));

   assign unused_bits = ^{set_cur.f1, set_cur.f2, set_cur.g0,
                          set_cur.k[31:IDX_W], set_cur.d[31:IDX_W],
                          set_new.k, set_new.f1, set_new.f2,
                          set_new.d, set_new.g0[31:IDX_W]};

   qpp_mod_add #(.W(IDX_W)) u_pi_add (
      .a (pi_q),
      .b (g_q),
      .k (k_cur),
      .y (pi_nxt)
   );

   qpp_mod_add #(.W(IDX_W)) u_g_add (
      .a (g_q),
      .b (d_cur),
      .k (k_cur),
      .y (g_nxt)
   );

`ifdef QPP_BYPASS_EN
   logic byp_q, byp_d;
`endif

   always_comb begin
      state_d = state_q;
      ksel_d  = ksel_q;
      idx_d   = idx_q;
      pi_d    = pi_q;
      g_d     = g_q;
      done_d  = 1'b0;
`ifdef QPP_BYPASS_EN
      byp_d   = byp_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               ksel_d  = k_sel;
               idx_d   = '0;
               pi_d    = '0;
               g_d     = g0_new;
`ifdef QPP_BYPASS_EN
               byp_d   = bypass;
`endif
            end
         end
         RUN: begin
            if (out_ready) begin
               if (at_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  pi_d  = pi_nxt;
                  g_d   = g_nxt;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ksel_q  <= 1'b0;
         idx_q   <= '0;
         pi_q    <= '0;
         g_q     <= '0;
         done_q  <= 1'b0;
`ifdef QPP_BYPASS_EN
         byp_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ksel_q  <= ksel_d;
         idx_q   <= idx_d;
         pi_q    <= pi_d;
         g_q     <= g_d;
         done_q  <= done_d;
`ifdef QPP_BYPASS_EN
         byp_q   <= byp_d;
`endif
      end
   end

   assign out_valid = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign out_idx   = idx_q;
   assign out_last  = out_valid & at_last;
   assign done      = done_q;

`ifdef QPP_BYPASS_EN
   assign out_pi = byp_q ? idx_q : pi_q;
`else
   assign out_pi = pi_q;
`endif

endmodule

// File: tb/tb_qpp_ind_gen.sv
// Scoreboard bench for qpp_ind_gen: expected beats come from direct
// evaluation of (f1*i + f2*i^2) mod K, checked by an independent monitor.
module tb_qpp_ind_gen;

   localparam int IDX_W = 14;
   localparam int K_A   = 1056;
   localparam int F1_A  = 17;
   localparam int F2_A  = 66;
   localparam int K_B   = 6144;
   localparam int F1_B  = 263;
   localparam int F2_B  = 480;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             k_sel = 1'b0;
   logic             out_ready = 1'b0;
`ifdef QPP_BYPASS_EN
   logic             bypass = 1'b0;
`endif
   logic             out_valid;
   logic [IDX_W-1:0] out_idx;
   logic [IDX_W-1:0] out_pi;
   logic             out_last;
   logic             busy;
   logic             done;

   always #5 clock = ~clock;

   qpp_ind_gen #(
      .IDX_W (IDX_W),
      .K_A   (K_A),
      .F1_A  (F1_A),
      .F2_A  (F2_A),
      .K_B   (K_B),
      .F1_B  (F1_B),
      .F2_B  (F2_B)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .k_sel     (k_sel),
`ifdef QPP_BYPASS_EN
      .bypass    (bypass),
`endif
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_pi    (out_pi),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      int idx;
      int pi;
      bit last;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   rnd_ready = 1'b0;
   bit   exp_done  = 1'b0;
   bit   prev_stall = 1'b0;
   int   prev_idx;
   int   prev_pi;
   bit   seen[16384];
   int   uniq = 0;
   bit   ok;

   task automatic chk(input string name, input longint act,
                      input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic int qpp(input int k, input int f1,
                              input int f2, input int i);
      longint v;
      v = longint'(f1) * i + longint'(f2) * i * i;
      return int'(v % k);
   endfunction

   task automatic push_block(input bit ks, input bit byp);
      int   k;
      exp_t e;
      k = ks ? K_B : K_A;
      for (int i = 0; i < k; i++) begin
         e.idx  = i;
         e.pi   = byp ? i :
                  (ks ? qpp(K_B, F1_B, F2_B, i)
                      : qpp(K_A, F1_A, F2_A, i));
         e.last = (i == k - 1);
         sb.push_back(e);
      end
      for (int i = 0; i < 16384; i++) seen[i] = 1'b0;
      uniq = 0;
   endtask

   // Called at posedge+1 with the DUT idle (or in its done cycle).
   task automatic begin_block(input bit ks, input bit byp);
      k_sel = ks;
`ifdef QPP_BYPASS_EN
      bypass = byp;
`endif
      start = 1'b1;
      push_block(ks, byp);
      @(posedge clock);
      #1;
      start = 1'b0;
      chk("latency_valid", out_valid, 1);
      chk("latency_busy", busy, 1);
   endtask

   task automatic drain(input int poke_at, input int stop_rem,
                        output bit done_ok);
      int cyc;
      cyc = 0;
      done_ok = 1'b0;
      while (cyc < 40000) begin
         if (sb.size() <= stop_rem) begin
            done_ok = 1'b1;
            break;
         end
         @(posedge clock);
         #1;
         cyc++;
         if (poke_at > 0 && cyc == poke_at) begin
            start = 1'b1;
            k_sel = ~k_sel;
         end
         if (poke_at > 0 && cyc == poke_at + 1) start = 1'b0;
      end
      if (!done_ok) begin
         chk("drain_timeout", sb.size(), stop_rem);
         sb.delete();
      end
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops one expected beat per accepted transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (done || exp_done) chk("done", done, exp_done);
            exp_done = 1'b0;
            if (out_valid) begin
               if (prev_stall) begin
                  chk("stall_idx", out_idx, prev_idx);
                  chk("stall_pi", out_pi, prev_pi);
               end
               if (out_ready) begin
                  if (sb.size() == 0) begin
                     chk("extra_beat", out_idx, -1);
                  end else begin
                     e = sb.pop_front();
                     chk("idx", out_idx, e.idx);
                     chk("pi", out_pi, e.pi);
                     chk("last", out_last, e.last);
                     if (!seen[out_pi]) uniq++;
                     seen[out_pi] = 1'b1;
                     if (e.last) exp_done = 1'b1;
                  end
               end
               prev_stall = !out_ready;
               prev_idx   = int'(out_idx);
               prev_pi    = int'(out_pi);
            end else begin
               prev_stall = 1'b0;
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_pi", out_pi, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      begin_block(1'b0, 1'b0);
      drain(0, 0, ok);
      repeat (3) @(posedge clock);
      #1;

      begin_block(1'b1, 1'b0);
      drain(0, 0, ok);
      chk("perm_unique", uniq, K_B);
      repeat (3) @(posedge clock);
      #1;

      rnd_ready = 1'b1;
      begin_block(1'b0, 1'b0);
      drain(0, 0, ok);
      begin_block(1'b1, 1'b0);
      drain(100, 0, ok);
      chk("idle_busy", busy, 0);
      rnd_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;

      begin_block(1'b1, 1'b0);
      drain(0, K_B - 500, ok);
      reset = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      sb.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("post_rst_busy", busy, 0);

      begin_block(1'b0, 1'b0);
      drain(0, 0, ok);
      repeat (3) @(posedge clock);
      #1;

`ifdef QPP_BYPASS_EN
      begin_block(1'b0, 1'b1);
      drain(0, 0, ok);
      repeat (3) @(posedge clock);
      #1;
`endif

      repeat (5) @(posedge clock);
      #1;
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
